button_debouncer: RTL and testbench

Per-channel debouncer for raw board push-buttons sampled on the board master clock. It sits directly upstream of the `edge_to_pulse` instances that generate load/add strobes. It synchronizes each asynchronous button input, filters mechanical bounce with a per-channel stability counter, and presents clean levels to the downstream edge detectors. Optional one-cycle press/release strobes can be compiled in.

---
 rtl/button_debouncer.sv | 106 ++++++++++
 tb/tb_button_debouncer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// Per-channel push-button debouncer: 2-flop synchronizer plus a stability counter per channel.
// Define BUTTON_DEBOUNCER_PULSE_EN to build the one-cycle press/release strobes; otherwise they are tied low.
module button_debouncer #(
  parameter int NUM_BTN      = 4,
  parameter int STABLE_COUNT = 500000,
  parameter int CNT_WIDTH    = 19
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [NUM_BTN-1:0] btn_out,
  output logic [NUM_BTN-1:0] press_pulse,
  output logic [NUM_BTN-1:0] release_pulse,
  output logic [NUM_BTN-1:0] dbg_settling
);

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_SETTLING = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(STABLE_COUNT - 1);

  logic [NUM_BTN-1:0]   s1;
  logic [NUM_BTN-1:0]   s2;
  state_t               state_q [NUM_BTN];
  state_t               state_d [NUM_BTN];
  logic [CNT_WIDTH-1:0] cnt     [NUM_BTN];
  logic [CNT_WIDTH-1:0] cnt_d   [NUM_BTN];
  logic [NUM_BTN-1:0]   accept;
  logic [NUM_BTN-1:0]   btn_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn_in;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_out <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        state_q[i] <= ST_STABLE;
        cnt[i]     <= '0;
      end
    end else begin
      btn_out <= btn_d;
      for (int i = 0; i < NUM_BTN; i++) begin
        state_q[i] <= state_d[i];
        cnt[i]     <= cnt_d[i];
      end
    end
  end

  // Any edge where s2 agrees with btn_out ends settling, so a bounce restarts the count.
  always_comb begin
    accept = '0;
    btn_d  = btn_out;
    for (int i = 0; i < NUM_BTN; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt[i];
      if (s2[i] != btn_out[i]) begin
        if (cnt[i] == CNT_MAX) begin
          accept[i]  = 1'b1;
          btn_d[i]   = s2[i];
          cnt_d[i]   = '0;
          state_d[i] = ST_STABLE;
        end else begin
          cnt_d[i]   = cnt[i] + CNT_WIDTH'(1);
          state_d[i] = ST_SETTLING;
        end
      end else begin
        cnt_d[i]   = '0;
        state_d[i] = ST_STABLE;
      end
    end
  end

  always_comb begin
    dbg_settling = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      dbg_settling[i] = (state_q[i] == ST_SETTLING);
    end
  end

`ifdef BUTTON_DEBOUNCER_PULSE_EN
  // Strobes land in the same cycle as the new btn_out value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      press_pulse   <= '0;
      release_pulse <= '0;
    end else begin
      press_pulse   <= accept & s2;
      release_pulse <= accept & ~s2;
    end
  end
`else
  assign press_pulse   = '0;
  assign release_pulse = '0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with NUM_BTN=4, STABLE_COUNT=4, CNT_WIDTH=2.
// Strobe expectations follow BUTTON_DEBOUNCER_PULSE_EN as seen by this compile.
module tb_button_debouncer;

  localparam int NB = 4;
  localparam int SC = 4;
  localparam int CW = 2;
`ifdef BUTTON_DEBOUNCER_PULSE_EN
  localparam bit PULSE_ON = 1'b1;
`else
  localparam bit PULSE_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [NB-1:0] btn_in;
  logic [NB-1:0] btn_out;
  logic [NB-1:0] press_pulse;
  logic [NB-1:0] release_pulse;
  logic [NB-1:0] dbg_settling;

  int total = 0;
  int bad   = 0;

  button_debouncer #(
    .NUM_BTN     (NB),
    .STABLE_COUNT(SC),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_in       (btn_in),
    .btn_out      (btn_out),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .dbg_settling (dbg_settling)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NB-1:0] pexp(input logic [NB-1:0] v);
    return PULSE_ON ? v : '0;
  endfunction

  // Advance n rising edges, leaving time 1 ns past the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_outs(input string tag, input logic [NB-1:0] eo,
                            input logic [NB-1:0] ep, input logic [NB-1:0] er);
    check({tag, "_out"}, 32'(btn_out), 32'(eo));
    check({tag, "_press"}, 32'(press_pulse), 32'(ep));
    check({tag, "_release"}, 32'(release_pulse), 32'(er));
  endtask

  initial begin
    int npress;

    // Reset with all buttons held.
    reset  = 1'b1;
    btn_in = 4'hF;
    step(2);
    check_outs("rst_held", 4'h0, 4'h0, 4'h0);
    check("rst_dbg", 32'(dbg_settling), 32'h0);
    reset = 1'b0;
    step(5);
    check_outs("held_pre", 4'h0, 4'h0, 4'h0);
    step(1);
    check_outs("held_acc", 4'hF, pexp(4'hF), 4'h0);
    step(1);
    check_outs("held_post", 4'hF, 4'h0, 4'h0);

    btn_in = 4'h0;
    step(6);
    check_outs("rel_all", 4'h0, 4'h0, pexp(4'hF));
    step(1);

    // Clean press on channel 1.
    btn_in = 4'h2;
    step(5);
    check_outs("press_pre", 4'h0, 4'h0, 4'h0);
    step(1);
    check_outs("press_acc", 4'h2, pexp(4'h2), 4'h0);
    step(1);
    check_outs("press_post", 4'h2, 4'h0, 4'h0);

    // Bounce on channel 2: 2 high, 2 low, ... ending on the high run at c=8.
    npress = 0;
    for (int c = 0; c < 10; c++) begin
      btn_in[2] = ((c / 2) % 2) == 0;
      step(1);
      check("bounce_out", 32'(btn_out), 32'h2);
      if (press_pulse[2]) npress++;
    end
    step(3);
    check_outs("bounce_pre", 4'h2, 4'h0, 4'h0);
    if (press_pulse[2]) npress++;
    step(1);
    check_outs("bounce_acc", 4'h6, pexp(4'h4), 4'h0);
    if (press_pulse[2]) npress++;
    step(1);
    check_outs("bounce_post", 4'h6, 4'h0, 4'h0);
    if (press_pulse[2]) npress++;
    check("bounce_npress", 32'(npress), PULSE_ON ? 32'd1 : 32'd0);

    // 3-cycle glitch on channel 0 is rejected.
    btn_in[0] = 1'b1;
    for (int c = 0; c < 11; c++) begin
      if (c == 3) btn_in[0] = 1'b0;
      step(1);
      check("glitch_out", 32'(btn_out), 32'h6);
      check("glitch_press", 32'(press_pulse), 32'h0);
    end

    // Release on channel 3 after bringing it up.
    btn_in[3] = 1'b1;
    step(6);
    check_outs("ch3_up", 4'hE, pexp(4'h8), 4'h0);
    btn_in[3] = 1'b0;
    step(5);
    check_outs("ch3_rel_pre", 4'hE, 4'h0, 4'h0);
    step(1);
    check_outs("ch3_rel_acc", 4'h6, 4'h0, pexp(4'h8));
    step(1);
    check_outs("ch3_rel_post", 4'h6, 4'h0, 4'h0);

    // Reset mid-settling on channel 1 (cnt=2).
    btn_in[1] = 1'b0;
    step(4);
    check("mid_dbg", 32'(dbg_settling), 32'h2);
    check("mid_cnt", 32'(dut.cnt[1]), 32'd2);
    #2 reset = 1'b1;
    #1;
    check_outs("mid_rst", 4'h0, 4'h0, 4'h0);
    check("mid_rst_cnt", 32'(dut.cnt[1]), 32'd0);
    check("mid_rst_dbg", 32'(dbg_settling), 32'h0);
    #1;
    btn_in = 4'h6;
    reset  = 1'b0;
    step(5);
    check_outs("after_rst_pre", 4'h0, 4'h0, 4'h0);
    step(1);
    check_outs("after_rst_acc", 4'h6, pexp(4'h6), 4'h0);
    step(1);
    check_outs("after_rst_post", 4'h6, 4'h0, 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
